divide_n: RTL and testbench
===========================

DIVIDE_N -- requirements
Module: divide_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 14, setting the dividend and quotient width (range 2..32).
REQ-002 The block SHALL have parameter DWIDTH, default 4, setting the divisor and remainder width (range 1..WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a new division.
REQ-006 The block SHALL have port value, input, WIDTH bits: unsigned dividend.
REQ-007 The block SHALL have port divisor, input, DWIDTH bits: unsigned divisor, runtime-selectable.
REQ-008 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port remainder, output, DWIDTH bits: registered result.
REQ-010 The block SHALL have port ready, output, 1 bit: result valid, idle.
REQ-011 The block SHALL have port busy, output, 1 bit: division in progress.
REQ-012 The block SHALL have port div_zero, output, 1 bit: last accepted divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 ready SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-015 start SHALL be sampled only in IDLE or DONE.
REQ-016 An accepted start SHALL latch value and divisor, load the step counter with WIDTH, clear ready and enter RUN.
REQ-017 start SHALL be ignored in RUN; operand input changes during RUN SHALL have no effect.
REQ-018 RUN SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-019 The internal partial remainder SHALL be DWIDTH+1 bits wide.
REQ-020 RUN SHALL last exactly WIDTH cycles: start sampled at edge 0 -> ready=1 after edge WIDTH.
REQ-021 quotient, remainder and div_zero SHALL be separate result registers, written only on the RUN->DONE transition, and held stable at all other times, including through a new RUN.
REQ-022 Results SHALL satisfy quotient*divisor + remainder == value and remainder < divisor for every divisor != 0.
REQ-023 DONE SHALL hold until the next accepted start.
REQ-024 DONE with start=1 SHALL go to RUN on the same edge.
REQ-025 Without a start, IDLE and DONE SHALL hold indefinitely.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, with quotient=0, remainder=0, ready=0, busy=0, div_zero=0 and counter=0.
REQ-027 Assertion of rst mid-RUN SHALL abort the division with no partial result visible.
REQ-028 The first start SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-029 Macro DIVIDE_N_DIVZERO_EN SHALL control divide-by-zero handling.
REQ-030 With DIVIDE_N_DIVZERO_EN defined, an accepted start with divisor=0 SHALL skip RUN, enter DONE on the next edge with quotient=all ones, remainder=value[DWIDTH-1:0] and div_zero=1.
REQ-031 With DIVIDE_N_DIVZERO_EN defined, div_zero SHALL clear on the next division with divisor!=0.
REQ-032 Without DIVIDE_N_DIVZERO_EN, div_zero SHALL be tied 0.
REQ-033 Without DIVIDE_N_DIVZERO_EN, divisor=0 SHALL run the full WIDTH cycles and yield quotient=all ones and remainder=value[DWIDTH-1:0].

Verification (WIDTH=14, DWIDTH=4)
REQ-034 value=4934, divisor=10, 1-cycle start after reset -> busy for 14 cycles; then ready=1 with quotient=493 and remainder=4.
REQ-035 value=16383, divisor=1 -> quotient=16383, remainder=0; value=9, divisor=10 -> quotient=0, remainder=9.
REQ-036 value=4934, divisor=0, macro defined -> ready 1 cycle after start, quotient=16383, remainder=6, div_zero=1. Macro undefined -> ready after 14 cycles, same quotient and remainder, div_zero=0.
REQ-037 start pulsed again at cycle 5 of a RUN with different operands -> ignored; the original result appears on schedule.
REQ-038 rst=0 at cycle 7 of a RUN -> all outputs 0 immediately; after release, a new start with value=100, divisor=7 -> quotient=14, remainder=2.

Source files
------------

// File: rtl/divide_n.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Define DIVIDE_N_DIVZERO_EN to short-circuit divide-by-zero and flag it on div_zero.
module divide_n #(
    parameter int WIDTH  = 14,
    parameter int DWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    input  logic [DWIDTH-1:0] divisor,
    output logic [WIDTH-1:0]  quotient,
    output logic [DWIDTH-1:0] remainder,
    output logic              ready,
    output logic              busy,
    output logic              div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  dvd;      // dividend bits shift out, quotient bits shift in
    logic [DWIDTH-1:0] dsr;
    logic [DWIDTH:0]   prem;
    logic [CW-1:0]     cnt;

    logic [DWIDTH+1:0] trial;
    logic              qbit;
    logic [DWIDTH:0]   prem_nxt;
    logic [WIDTH-1:0]  dvd_nxt;

    // Partial remainder stays below the divisor, so DWIDTH+1 bits never overflow;
    // with a zero divisor it simply keeps the low bits of the dividend.
    always_comb begin
        trial    = {prem, dvd[WIDTH-1]};
        qbit     = (trial >= {2'b00, dsr});
        prem_nxt = (DWIDTH+1)'(qbit ? (trial - {2'b00, dsr}) : trial);
        dvd_nxt  = {dvd[WIDTH-2:0], qbit};
    end

`ifndef DIVIDE_N_DIVZERO_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
`ifdef DIVIDE_N_DIVZERO_EN
            div_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd   <= value;
                        dsr   <= divisor;
                        prem  <= '0;
                        cnt   <= CW'(WIDTH);
                        ready <= 1'b0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef DIVIDE_N_DIVZERO_EN
                        if (divisor == '0) begin
                            cnt       <= '0;
                            state     <= DONE;
                            busy      <= 1'b0;
                            ready     <= 1'b1;
                            quotient  <= '1;
                            remainder <= value[DWIDTH-1:0];
                            div_zero  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    dvd  <= dvd_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                        quotient  <= dvd_nxt;
                        remainder <= prem_nxt[DWIDTH-1:0];
`ifdef DIVIDE_N_DIVZERO_EN
                        div_zero  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_n.sv
// Scoreboard bench for divide_n (WIDTH=14, DWIDTH=4): directed vectors, decoupled monitor.
module tb_divide_n;

    localparam int W  = 14;
    localparam int DW = 4;

`ifdef DIVIDE_N_DIVZERO_EN
    localparam logic DZ    = 1'b1;
    localparam int   DZLAT = 0;
    localparam int   DZBSY = 0;
`else
    localparam logic DZ    = 1'b0;
    localparam int   DZLAT = W;
    localparam int   DZBSY = W;
`endif

    typedef struct {
        logic [W-1:0]  q;
        logic [DW-1:0] r;
        logic          dz;
        int            lat;
        int            bsy;
        int            t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  value = '0;
    logic [DW-1:0] divisor = '0;
    logic [W-1:0]  quotient;
    logic [DW-1:0] remainder;
    logic          ready, busy, div_zero;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    divide_n #(.WIDTH(W), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .ready(ready), .busy(busy),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic issue(input logic [W-1:0] v, input logic [DW-1:0] d,
                         input logic [W-1:0] q, input logic [DW-1:0] r,
                         input logic dz, input int lat, input int bsy);
        exp_t e;
        start = 1'b1; value = v; divisor = d;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.bsy = bsy; e.t0 = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: a result event is ready rising, or ready staying up after an accepted start.
    logic prev_rdy = 1'b0;
    logic prev_acc = 1'b0;
    int   bcnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            bcnt = 0; prev_rdy = 1'b0; prev_acc = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (ready && (!prev_rdy || prev_acc)) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_ready: got result q=%0d with empty scoreboard", quotient);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", 32'(quotient), 32'(e.q));
                    chk("remainder", 32'(remainder), 32'(e.r));
                    chk("div_zero", 32'(div_zero), 32'(e.dz));
                    chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                    chk("busy_cycles", 32'(bcnt), 32'(e.bsy));
                end
                bcnt = 0;
            end
            prev_acc = start && !busy;
            prev_rdy = ready;
        end
    end

    initial begin
        #12;
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_div_zero", 32'(div_zero), 0);

        // First start on the very first edge with reset released.
        @(posedge clk); #2;
        rst = 1'b1;
        issue(14'd4934, 4'd10, 14'd493, 4'd4, 1'b0, W, W);
        drain();

        issue(14'd16383, 4'd1, 14'd16383, 4'd0, 1'b0, W, W);
        drain();
        issue(14'd9, 4'd10, 14'd0, 4'd9, 1'b0, W, W);
        drain();
        issue(14'd1000, 4'd3, 14'd333, 4'd1, 1'b0, W, W);
        drain();

        // Restart from DONE; result regs hold the old value through RUN; a start mid-RUN is ignored.
        issue(14'd12345, 4'd15, 14'd823, 4'd0, 1'b0, W, W);
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1; value = 14'd9; divisor = 4'd10;
        chk("held_quotient", 32'(quotient), 333);
        chk("held_remainder", 32'(remainder), 1);
        chk("busy_midrun", 32'(busy), 1);
        @(posedge clk); #2;
        start = 1'b0;
        drain();

        issue(14'd4934, 4'd0, 14'd16383, 4'd6, DZ, DZLAT, DZBSY);
        drain();
        issue(14'd200, 4'd13, 14'd15, 4'd5, 1'b0, W, W);
        drain();
        issue(14'd16383, 4'd15, 14'd1092, 4'd3, 1'b0, W, W);
        drain();
        issue(14'd0, 4'd5, 14'd0, 4'd0, 1'b0, W, W);
        drain();

        // Reset at cycle 7 of a RUN aborts it with everything cleared at once.
        issue(14'd4934, 4'd10, 14'd493, 4'd4, 1'b0, W, W);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_quotient", 32'(quotient), 0);
        chk("abort_remainder", 32'(remainder), 0);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_div_zero", 32'(div_zero), 0);
        repeat (3) @(posedge clk);
        #2;
        chk("abort_ready_held", 32'(ready), 0);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("idle_ready", 32'(ready), 0);
        chk("idle_busy", 32'(busy), 0);
        issue(14'd100, 4'd7, 14'd14, 4'd2, 1'b0, W, W);
        drain();

        // DONE holds with no start.
        repeat (5) @(posedge clk);
        #2;
        chk("done_hold_ready", 32'(ready), 1);
        chk("done_hold_quotient", 32'(quotient), 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
